reshape_out: RTL and testbench

- Inverse of the load-side reshaper. Takes one packed PE-array result vector of `PE_COL*`PE_ROW` words, each `DWIDTH` bits, and serialises it into single-word memory writes at consecutive addresses.
- Sits between the PE array output and the result memory write port.
- Uses the same packing convention as the input side: element 0 occupies the most-significant slice.

---
 rtl/reshape_out_pkg.sv | 22 ++
 rtl/reshape_out_if.sv | 30 +++
 rtl/reshape_out_idx.sv | 75 +++++++
 rtl/reshape_out.sv | 140 ++++++++++++++
 tb/tb_reshape_out.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/reshape_out_pkg.sv
// Shared definitions for the result-side reshaper: default array geometry,
// word/address widths, FSM state encoding and a counter-width helper.
// Element slice convention: element 0 occupies the most-significant DWIDTH bits.
package reshape_out_pkg;

    localparam int DEF_DWIDTH = 8;
    localparam int DEF_AWIDTH = 8;
    localparam int DEF_PE_ROW = 2;
    localparam int DEF_PE_COL = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        STORE = 2'b01,
        DONE  = 2'b11
    } state_t;

    // Width of a counter that must hold 0..n-1; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/reshape_out_if.sv
// Vector-in / word-out bus of the reshape_out block.
// slave  : the reshaper itself (consumes vectors, produces memory writes).
// master : the surrounding logic (PE array result side plus result memory).
interface reshape_out_if #(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 8,
    parameter int NUM_EL = 4
) ();

    logic [NUM_EL*DWIDTH-1:0] din;
    logic                     in_valid;
    logic                     in_ready;
    logic [AWIDTH-1:0]        base_addr;
    logic                     store_en;
    logic [AWIDTH-1:0]        store_addr;
    logic [DWIDTH-1:0]        store_data;
    logic                     store_ready;
    logic                     done;

    modport slave (
        input  din, in_valid, base_addr, store_ready,
        output in_ready, store_en, store_addr, store_data, done
    );

    modport master (
        output din, in_valid, base_addr, store_ready,
        input  in_ready, store_en, store_addr, store_data, done
    );

endinterface

// File: rtl/reshape_out_idx.sv
// Word counter and element-index generator for reshape_out.
// Produces the element index of the word that follows the one currently
// presented, and a flag marking the last word of the vector.
// Build option RESHAPE_OUT_TRANSPOSE_EN: column-major order from a
// (row, col) counter pair, row advancing fastest; no divider is needed.
module reshape_out_idx
    import reshape_out_pkg::*;
#(
    parameter int PE_ROW = DEF_PE_ROW,
    parameter int PE_COL = DEF_PE_COL,
    parameter int NUM_EL = PE_ROW * PE_COL,
    parameter int IDX_W  = cnt_w(NUM_EL)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,      // new vector accepted: restart at word 0
    input  logic             advance,   // current word accepted and not last
    output logic [IDX_W-1:0] idx_next,  // element index of the following word
    output logic             last       // current word is the final one
);

    // NOTE: state registers use non-blocking (<=) assignments so every flop
    // samples pre-edge values; blocking here would create order-dependent races.

`ifdef RESHAPE_OUT_TRANSPOSE_EN
    localparam int ROW_W = cnt_w(PE_ROW);
    localparam int COL_W = cnt_w(PE_COL);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(PE_ROW - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(PE_COL - 1);

    logic [ROW_W-1:0] row_q, row_n;
    logic [COL_W-1:0] col_q, col_n;
    logic             row_wrap;

    assign row_wrap = (row_q == ROW_LAST);
    assign row_n    = row_wrap ? '0 : row_q + ROW_W'(1);
    assign col_n    = row_wrap ? col_q + COL_W'(1) : col_q;

    // Row/column position of the word currently presented.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
            col_q <= '0;
        end else if (load) begin
            row_q <= '0;
            col_q <= '0;
        end else if (advance) begin
            row_q <= row_n;
            col_q <= col_n;
        end
    end

    assign idx_next = IDX_W'(row_n) * IDX_W'(PE_COL) + IDX_W'(col_n);
    assign last     = row_wrap && (col_q == COL_LAST);
`else
    localparam logic [IDX_W-1:0] K_LAST = IDX_W'(NUM_EL - 1);

    logic [IDX_W-1:0] k_q;

    // Index of the word currently presented; equals its element index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q <= '0;
        end else if (load) begin
            k_q <= '0;
        end else if (advance) begin
            k_q <= k_q + IDX_W'(1);
        end
    end

    assign idx_next = k_q + IDX_W'(1);
    assign last     = (k_q == K_LAST);
`endif

endmodule

// File: rtl/reshape_out.sv
// reshape_out: serialises one packed PE-array result vector into single-word
// memory writes at consecutive addresses (base, base+1, ... modulo 2^AWIDTH).
// One vector is buffered at a time; a new one is accepted only from IDLE.
// Build option RESHAPE_OUT_TRANSPOSE_EN selects column-major word order
// (handled inside reshape_out_idx); timing is identical in both builds.
module reshape_out
    import reshape_out_pkg::*;
#(
    parameter int DWIDTH = DEF_DWIDTH,
    parameter int AWIDTH = DEF_AWIDTH,
    parameter int PE_ROW = DEF_PE_ROW,
    parameter int PE_COL = DEF_PE_COL
) (
    input  logic          clk,
    input  logic          rst_n,
    reshape_out_if.slave  bus
);

    localparam int NUM_EL = PE_ROW * PE_COL;
    localparam int VW     = NUM_EL * DWIDTH;
    localparam int IDX_W  = cnt_w(NUM_EL);

    state_t            state_q, state_n;
    logic [VW-1:0]     buf_q, buf_d;
    logic              in_ready_q, in_ready_d;
    logic              store_en_q, store_en_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic [DWIDTH-1:0] data_q, data_d;
    logic              done_q, done_d;

    logic              accept_in;
    logic              accept_wr;
    logic              idx_last;
    logic [IDX_W-1:0]  idx_next;
    logic [VW-1:0]     buf_shift;

    assign accept_in = (state_q == IDLE) && bus.in_valid && in_ready_q;
    assign accept_wr = (state_q == STORE) && bus.store_ready;

    reshape_out_idx #(
        .PE_ROW (PE_ROW),
        .PE_COL (PE_COL),
        .NUM_EL (NUM_EL),
        .IDX_W  (IDX_W)
    ) u_idx (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept_in),
        .advance  (accept_wr && !idx_last),
        .idx_next (idx_next),
        .last     (idx_last)
    );

    // Element idx_next moved down to the least-significant slice.
    assign buf_shift = buf_q >> (DWIDTH * (NUM_EL - 1 - int'(idx_next)));

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // FSM next-state logic.
    always_comb begin
        // NOTE: assigning every combinational output a default first keeps all
        // paths covered, so no latch is inferred when a branch omits it.
        state_n = state_q;
        case (state_q)
            IDLE:    if (accept_in) state_n = STORE;
            STORE:   if (accept_wr && idx_last) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // FSM output logic: next values of the buffer and the registered store port.
    always_comb begin
        buf_d      = buf_q;
        store_en_d = store_en_q;
        addr_d     = addr_q;
        data_d     = data_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept_in) begin
                    buf_d      = bus.din;
                    store_en_d = 1'b1;
                    addr_d     = bus.base_addr;
                    // Word 0 is element 0 in either order.
                    data_d     = bus.din[VW-1 -: DWIDTH];
                end
            end
            STORE: begin
                if (accept_wr) begin
                    if (idx_last) begin
                        store_en_d = 1'b0;
                        done_d     = 1'b1;
                    end else begin
                        addr_d = addr_q + AWIDTH'(1);
                        data_d = buf_shift[DWIDTH-1:0];
                    end
                end
            end
            default: ;
        endcase
    end

    assign in_ready_d = (state_n == IDLE);

    // Vector buffer and store-port registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the vector buffer is cleared on reset so a discarded vector
            // can never leak into later writes; it is flops, not a RAM macro.
            buf_q      <= '0;
            in_ready_q <= 1'b0;
            store_en_q <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            done_q     <= 1'b0;
        end else begin
            buf_q      <= buf_d;
            in_ready_q <= in_ready_d;
            store_en_q <= store_en_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            done_q     <= done_d;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.store_en   = store_en_q;
    assign bus.store_addr = addr_q;
    assign bus.store_data = data_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_reshape_out.sv
// Self-checking bench for reshape_out (2x2 array, 8-bit words, 8-bit addresses).
// Expected writes come from a behavioural model: word k of a vector is element
// k (or the column-major element when RESHAPE_OUT_TRANSPOSE_EN is defined),
// at address base+k modulo 256. Inputs are driven and outputs sampled on the
// falling edge; the DUT changes state on the rising edge.
module tb_reshape_out;

    localparam int DW = 8;
    localparam int AW = 8;
    localparam int PR = 2;
    localparam int PC = 2;
    localparam int NE = PR * PC;
    localparam int VW = NE * DW;

    logic clk;
    logic rst_n;

    int n_cmp;
    int n_err;

    reshape_out_if #(.DWIDTH(DW), .AWIDTH(AW), .NUM_EL(NE)) bus ();

    reshape_out #(
        .DWIDTH (DW),
        .AWIDTH (AW),
        .PE_ROW (PR),
        .PE_COL (PC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: element number carried by word k of a vector.
    function automatic int ref_elem(input int k);
`ifdef RESHAPE_OUT_TRANSPOSE_EN
        return (k % PR) * PC + (k / PR);
`else
        return k;
`endif
    endfunction

    // Reference: data of word k, element 0 in the top slice.
    function automatic logic [DW-1:0] ref_data(input logic [VW-1:0] vec, input int k);
        logic [VW-1:0] t;
        t = vec >> ((NE - 1 - ref_elem(k)) * DW);
        return t[DW-1:0];
    endfunction

    // Wait (bounded) for in_ready at a falling edge; reports whether it came.
    task automatic wait_ready(output bit ok);
        int waited;
        waited = 0;
        while (bus.in_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("in_ready_wait", bus.in_ready, 1'b1);
        ok = (bus.in_ready === 1'b1);
    endtask

    // Send one vector and follow its writes cycle by cycle.
    // stall_mode 0: store_ready always 1; 1: random stalls (max 3 in a row);
    // 2: three stall cycles while word 2 is presented.
    task automatic run_vec(input logic [VW-1:0] vec, input logic [AW-1:0] base,
                           input int stall_mode, input bit junk);
        bit ok;
        bit rdy;
        int k;
        int stalls;
        wait_ready(ok);
        if (!ok) return;
        bus.in_valid  = 1'b1;
        bus.din       = vec;
        bus.base_addr = base;
        @(negedge clk);
        // Post-handshake changes must be ignored.
        bus.in_valid  = 1'b0;
        bus.din       = VW'($urandom);
        bus.base_addr = AW'($urandom);
        k = 0;
        stalls = 0;
        while (k < NE) begin
            check("store_en", bus.store_en, 1'b1);
            check("store_addr", bus.store_addr, AW'(base + k));
            check("store_data", bus.store_data, ref_data(vec, k));
            check("in_ready_busy", bus.in_ready, 1'b0);
            check("done_early", bus.done, 1'b0);
            case (stall_mode)
                0:       rdy = 1'b1;
                1:       rdy = (stalls >= 3) || ($urandom_range(0, 2) != 0);
                default: rdy = !(k == 2 && stalls < 3);
            endcase
            bus.store_ready = rdy;
            if (junk) begin
                bus.in_valid = 1'($urandom_range(0, 1));
                bus.din      = 32'hAABBCCDD;
            end
            @(negedge clk);
            if (rdy) begin
                k++;
                stalls = 0;
            end else begin
                stalls++;
            end
        end
        check("done_pulse", bus.done, 1'b1);
        check("store_en_off", bus.store_en, 1'b0);
        check("in_ready_done", bus.in_ready, 1'b0);
        bus.in_valid    = 1'b0;
        bus.store_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        check("done_clear", bus.done, 1'b0);
        check("in_ready_back", bus.in_ready, 1'b1);
        check("store_en_idle", bus.store_en, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit ok;
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.din         = '0;
        bus.in_valid    = 1'b0;
        bus.base_addr   = '0;
        bus.store_ready = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_in_ready", bus.in_ready, 1'b0);
        check("rst_store_en", bus.store_en, 1'b0);
        check("rst_store_addr", bus.store_addr, '0);
        check("rst_store_data", bus.store_data, '0);
        check("rst_done", bus.done, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready_after_rst", bus.in_ready, 1'b1);

        // Basic sequence, stall during word 2, address wrap, busy in_valid.
        run_vec(32'h11223344, 8'h10, 0, 1'b0);
        run_vec(32'h11223344, 8'h10, 2, 1'b0);
        run_vec(32'h11223344, 8'hFE, 0, 1'b0);
        run_vec(32'h11223344, 8'h20, 0, 1'b1);
        run_vec(32'h11223344, 8'h00, 0, 1'b0);

        // Reset in the middle of a vector.
        wait_ready(ok);
        bus.in_valid    = 1'b1;
        bus.din         = 32'h55667788;
        bus.base_addr   = 8'h40;
        bus.store_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("mid_first_data", bus.store_data, ref_data(32'h55667788, 0));
        @(negedge clk);
        check("mid_second_addr", bus.store_addr, 8'h41);
        #2 rst_n = 1'b0;
        #1;
        check("async_store_en", bus.store_en, 1'b0);
        check("async_in_ready", bus.in_ready, 1'b0);
        check("async_done", bus.done, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_hold_store_en", bus.store_en, 1'b0);
            check("rst_hold_done", bus.done, 1'b0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_store_en", bus.store_en, 1'b0);
            check("post_rst_done", bus.done, 1'b0);
            check("post_rst_in_ready", bus.in_ready, 1'b1);
        end
        run_vec(32'h99AABBCC, 8'h80, 0, 1'b0);

        // Randomised vectors, bases, stalls and busy-time in_valid noise.
        for (int n = 0; n < 40; n++) begin
            run_vec(VW'($urandom), AW'($urandom), 1, 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
